// File: rtl/tt_mux_pkg.sv
// Shared types and bus-layout helpers for the sequenced per-project mux slot.
package tt_mux_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // iw = {uio_in, ui_in, rst_req_n}; ow = {uio_oe, uio_out, uo_out}
    localparam int unsigned IW_RST_POS = 0;
    localparam int unsigned IW_UI_POS  = 1;
    localparam int unsigned OW_UO_POS  = 0;

    function automatic int unsigned iw_width(input int unsigned ui_w, input int unsigned uio_w);
        return uio_w + ui_w + 1;
    endfunction

    function automatic int unsigned ow_width(input int unsigned uo_w, input int unsigned uio_w);
        return 2 * uio_w + uo_w;
    endfunction

    function automatic int unsigned iw_uio_pos(input int unsigned ui_w);
        return IW_UI_POS + ui_w;
    endfunction

    function automatic int unsigned ow_uio_pos(input int unsigned uo_w);
        return OW_UO_POS + uo_w;
    endfunction

    function automatic int unsigned ow_oe_pos(input int unsigned uo_w, input int unsigned uio_w);
        return OW_UO_POS + uo_w + uio_w;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned rst_cycles,
                                              input int unsigned drain_cycles);
        int unsigned m;
        m = (rst_cycles > drain_cycles) ? rst_cycles : drain_cycles;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/tt_sync.sv
// N-stage single-bit synchroniser, cleared asynchronously; N=0 is a plain wire.
module tt_sync #(
    parameter int unsigned N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    generate
        if (N == 0) begin : g_wire
            assign q = d;
        end else begin : g_chain
            logic [N-1:0] chain;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    chain <= '0;
                end else begin
                    chain[0] <= d;
                    for (int i = 1; i < N; i++) begin
                        chain[i] <= chain[i-1];
                    end
                end
            end

            assign q = chain[N-1];
        end
    endgenerate

endmodule

// File: rtl/tt_mux_slot.sv
// Sequenced mux slot: unpacks the mux bus to one project, holds it in reset
// around enable/disable, isolates its outputs outside RUN and counts RUN cycles.
module tt_mux_slot
    import tt_mux_pkg::*;
#(
    parameter int unsigned UI_W         = 8,
    parameter int unsigned UO_W         = 8,
    parameter int unsigned UIO_W        = 8,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned RST_CYCLES   = 4,
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned IN_REG       = 1,
    parameter int unsigned OUT_REG      = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 ena,
    input  logic [iw_width(UI_W, UIO_W)-1:0]     iw,
    output logic [ow_width(UO_W, UIO_W)-1:0]     ow,
    output logic                                 prj_ena,
    output logic                                 prj_rst_n,
    output logic [UI_W-1:0]                      prj_ui_in,
    output logic [UIO_W-1:0]                     prj_uio_in,
    input  logic [UO_W-1:0]                      prj_uo_out,
    input  logic [UIO_W-1:0]                     prj_uio_out,
    input  logic [UIO_W-1:0]                     prj_uio_oe,
    output logic [1:0]                           state,
    output logic [CNT_W-1:0]                     run_cycles
);

    localparam int unsigned IW_W       = iw_width(UI_W, UIO_W);
    localparam int unsigned OW_W       = ow_width(UO_W, UIO_W);
    localparam int unsigned CW         = cnt_width(RST_CYCLES, DRAIN_CYCLES);
    localparam int unsigned UIO_IN_POS = iw_uio_pos(UI_W);
    localparam logic [CW-1:0] RST_LOAD   = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);

    logic            ena_s;
    logic [IW_W-1:0] in_path;
    logic [OW_W-1:0] out_path;
    logic [OW_W-1:0] prj_out_bus;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] run_q, run_d;
    logic             prj_ena_q, prj_ena_d;
    logic             prj_rst_q, prj_rst_d;
    logic             io_live;

    tt_sync #(.N(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ena),
        .q     (ena_s)
    );

    assign prj_out_bus = {prj_uio_oe, prj_uio_out, prj_uo_out};

    generate
        if (IN_REG != 0) begin : g_in_reg
            logic [IW_W-1:0] in_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) in_q <= '0;
                else        in_q <= iw;
            end
            assign in_path = in_q;
        end else begin : g_in_comb
            assign in_path = iw;
        end

        if (OUT_REG != 0) begin : g_out_reg
            logic [OW_W-1:0] out_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) out_q <= '0;
                else        out_q <= prj_out_bus;
            end
            assign out_path = out_q;
        end else begin : g_out_comb
            assign out_path = prj_out_bus;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_OFF;
            cnt_q     <= '0;
            run_q     <= '0;
            prj_ena_q <= 1'b0;
            prj_rst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            run_q     <= run_d;
            prj_ena_q <= prj_ena_d;
            prj_rst_q <= prj_rst_d;
        end
    end

    // Sequencer: a disable always drains fully, even if ena returns mid-drain
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        case (state_q)
            ST_OFF: begin
                if (ena_s) begin
                    state_d = ST_RESET;
                    cnt_d   = RST_LOAD;
                    run_d   = '0;
                end
            end
            ST_RESET: begin
                if (!ena_s) begin
                    state_d = ST_DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_RUN: begin
                if (run_q != '1) run_d = run_q + CNT_W'(1);
                if (!ena_s) begin
                    state_d = ST_DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0) begin
                    if (ena_s) begin
                        state_d = ST_RESET;
                        cnt_d   = RST_LOAD;
                        run_d   = '0;
                    end else begin
                        state_d = ST_OFF;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = ST_OFF;
        endcase
        prj_ena_d = (state_d != ST_OFF);
        prj_rst_d = (state_d == ST_RUN) && in_path[IW_RST_POS];
    end

    assign io_live    = (state_q == ST_RESET) || (state_q == ST_RUN);
    assign prj_ui_in  = io_live ? in_path[IW_UI_POS +: UI_W]    : '0;
    assign prj_uio_in = io_live ? in_path[UIO_IN_POS +: UIO_W]  : '0;
    // Gated on the current state so outputs (and uio_oe) drop the cycle DRAIN begins
    assign ow         = (state_q == ST_RUN) ? out_path : '0;

    assign state      = state_q;
    assign run_cycles = run_q;
    assign prj_ena    = prj_ena_q;
    assign prj_rst_n  = prj_rst_q;

endmodule

// File: tb/tb_tt_mux_slot.sv
// Bench for tt_mux_slot: default instance plus a CNT_W=4 pass-through instance, shared stimulus.
module tb_tt_mux_slot;

    localparam int SYNC = 2;
    localparam int RSTC = 4;
    localparam int DRNC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic [16:0] iw;
    logic [7:0]  p_uo, p_uio, p_oe;

    logic [23:0] a_ow, b_ow;
    logic        a_pena, b_pena, a_prst, b_prst;
    logic [7:0]  a_ui, b_ui, a_uio, b_uio;
    logic [1:0]  a_state, b_state;
    logic [15:0] a_run;
    logic [3:0]  b_run;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tt_mux_slot u_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .iw(iw), .ow(a_ow),
        .prj_ena(a_pena), .prj_rst_n(a_prst), .prj_ui_in(a_ui), .prj_uio_in(a_uio),
        .prj_uo_out(p_uo), .prj_uio_out(p_uio), .prj_uio_oe(p_oe),
        .state(a_state), .run_cycles(a_run)
    );

    tt_mux_slot #(.CNT_W(4), .IN_REG(0), .OUT_REG(0)) u_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .iw(iw), .ow(b_ow),
        .prj_ena(b_pena), .prj_rst_n(b_prst), .prj_ui_in(b_ui), .prj_uio_in(b_uio),
        .prj_uo_out(p_uo), .prj_uio_out(p_uio), .prj_uio_oe(p_oe),
        .state(b_state), .run_cycles(b_run)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0..3 = OFF/RESET/RUN/DRAIN
    int          m_phase, m_remain, m_runs_a, m_runs_b, m_es;
    int          m_sync[$];
    logic [16:0] m_in_a;
    logic [23:0] m_out_a;
    logic        m_prst_a, m_prst_b;

    task automatic model_reset();
        m_phase  = 0;
        m_remain = 0;
        m_runs_a = 0;
        m_runs_b = 0;
        m_in_a   = '0;
        m_out_a  = '0;
        m_prst_a = 1'b0;
        m_prst_b = 1'b0;
        m_sync.delete();
        for (int i = 0; i < SYNC; i++) m_sync.push_back(0);
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            m_es = m_sync[$];
            case (m_phase)
                0: if (m_es != 0) begin
                       m_phase = 1; m_remain = RSTC - 1; m_runs_a = 0; m_runs_b = 0;
                   end
                1: if (m_es == 0) begin
                       m_phase = 3; m_remain = DRNC - 1;
                   end else if (m_remain == 0) m_phase = 2;
                   else m_remain--;
                2: begin
                       if (m_runs_a < 65535) m_runs_a++;
                       if (m_runs_b < 15) m_runs_b++;
                       if (m_es == 0) begin m_phase = 3; m_remain = DRNC - 1; end
                   end
                default: if (m_remain == 0) begin
                       if (m_es != 0) begin
                           m_phase = 1; m_remain = RSTC - 1; m_runs_a = 0; m_runs_b = 0;
                       end else m_phase = 0;
                   end else m_remain--;
            endcase
            m_prst_a = (m_phase == 2) ? m_in_a[0] : 1'b0;
            m_prst_b = (m_phase == 2) ? iw[0] : 1'b0;
            m_in_a   = iw;
            m_out_a  = {p_oe, p_uio, p_uo};
            m_sync.push_front(int'(ena));
            void'(m_sync.pop_back());
        end
    end

    logic [1:0]  e_state;
    logic        e_pena, e_prst_a, e_prst_b, live;
    logic [7:0]  e_ui_a, e_uio_a, e_ui_b, e_uio_b;
    logic [23:0] e_ow_a, e_ow_b;
    logic [15:0] e_run_a;
    logic [3:0]  e_run_b;

    always @(negedge clk) begin
        if (!rst_n) begin
            e_state = '0; e_pena = 1'b0; e_prst_a = 1'b0; e_prst_b = 1'b0;
            e_ui_a = '0; e_uio_a = '0; e_ui_b = '0; e_uio_b = '0;
            e_ow_a = '0; e_ow_b = '0; e_run_a = '0; e_run_b = '0;
        end else begin
            live     = (m_phase == 1) || (m_phase == 2);
            e_state  = 2'(m_phase);
            e_pena   = (m_phase != 0);
            e_prst_a = m_prst_a;
            e_prst_b = m_prst_b;
            e_ui_a   = live ? m_in_a[8:1]  : 8'h00;
            e_uio_a  = live ? m_in_a[16:9] : 8'h00;
            e_ui_b   = live ? iw[8:1]      : 8'h00;
            e_uio_b  = live ? iw[16:9]     : 8'h00;
            e_ow_a   = (m_phase == 2) ? m_out_a : 24'h0;
            e_ow_b   = (m_phase == 2) ? {p_oe, p_uio, p_uo} : 24'h0;
            e_run_a  = 16'(m_runs_a);
            e_run_b  = 4'(m_runs_b);
        end
        check("state_a", 32'(a_state), 32'(e_state));
        check("state_b", 32'(b_state), 32'(e_state));
        check("prj_ena_a", 32'(a_pena), 32'(e_pena));
        check("prj_ena_b", 32'(b_pena), 32'(e_pena));
        check("prj_rst_n_a", 32'(a_prst), 32'(e_prst_a));
        check("prj_rst_n_b", 32'(b_prst), 32'(e_prst_b));
        check("ui_in_a", 32'(a_ui), 32'(e_ui_a));
        check("uio_in_a", 32'(a_uio), 32'(e_uio_a));
        check("ui_in_b", 32'(b_ui), 32'(e_ui_b));
        check("uio_in_b", 32'(b_uio), 32'(e_uio_b));
        check("ow_a", 32'(a_ow), 32'(e_ow_a));
        check("ow_b", 32'(b_ow), 32'(e_ow_b));
        check("run_a", 32'(a_run), 32'(e_run_a));
        check("run_b", 32'(b_run), 32'(e_run_b));
    end

    logic [16:0] v_iw [4] = '{{8'h11, 8'h22, 1'b1}, {8'hF0, 8'h0F, 1'b0},
                              {8'h00, 8'hFF, 1'b1}, {8'h81, 8'h18, 1'b1}};
    logic [23:0] v_po [4] = '{24'hFF0001, 24'h00AA55, 24'h80017E, 24'h3CC399};

    // Advance n rising edges; inputs change 2 time units after each edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0; iw = '0;
        p_uo = '0; p_uio = '0; p_oe = '0;
        tick(3);
        check("lit_rst_state", 32'(a_state), 32'd0);
        check("lit_rst_prst", 32'(a_prst), 32'd0);
        check("lit_rst_ow", 32'(a_ow), 32'd0);
        rst_n = 1'b1;
        tick(1);

        // Enable: ena seen through 2 sync stages, RESET after edge 3, RUN after edge 7
        ena = 1'b1;
        tick(2);
        check("lit_pre_reset_state", 32'(a_state), 32'd0);
        tick(1);
        check("lit_reset_state", 32'(a_state), 32'd1);
        check("lit_reset_pena", 32'(a_pena), 32'd1);
        check("lit_reset_prst", 32'(a_prst), 32'd0);
        tick(3);
        check("lit_reset_last_state", 32'(b_state), 32'd1);
        tick(1);
        check("lit_run_state", 32'(a_state), 32'd2);
        check("lit_run_ow_idle", 32'(a_ow), 32'd0);

        iw = {8'hA5, 8'h3C, 1'b1};
        {p_oe, p_uio, p_uo} = 24'h0FFF5A;
        #1;
        check("lit_comb_ui_b", 32'(b_ui), 32'h3C);
        check("lit_comb_ow_b", 32'(b_ow), 32'h0FFF5A);
        check("lit_reg_ui_a_lag", 32'(a_ui), 32'h00);
        tick(1);
        check("lit_reg_ui_a", 32'(a_ui), 32'h3C);
        check("lit_reg_uio_a", 32'(a_uio), 32'hA5);
        check("lit_reg_ow_a", 32'(a_ow), 32'h0FFF5A);
        check("lit_prst_b", 32'(b_prst), 32'd1);
        check("lit_run1_a", 32'(a_run), 32'd1);
        tick(1);
        check("lit_prst_a", 32'(a_prst), 32'd1);

        for (int i = 0; i < 18; i++) begin
            iw = v_iw[i % 4];
            {p_oe, p_uio, p_uo} = v_po[i % 4];
            tick(1);
        end
        check("lit_run20_a", 32'(a_run), 32'd20);
        check("lit_sat_b", 32'(b_run), 32'd15);

        // Disable: DRAIN 3 edges later, 2 drain cycles, then OFF
        iw = {8'hA5, 8'h3C, 1'b1};
        {p_oe, p_uio, p_uo} = 24'h0FFF5A;
        ena = 1'b0;
        tick(2);
        check("lit_still_run", 32'(a_state), 32'd2);
        tick(1);
        check("lit_drain_state", 32'(a_state), 32'd3);
        check("lit_drain_ow_a", 32'(a_ow), 32'd0);
        check("lit_drain_ow_b", 32'(b_ow), 32'd0);
        check("lit_drain_pena", 32'(a_pena), 32'd1);
        check("lit_drain_prst", 32'(b_prst), 32'd0);
        tick(1);
        check("lit_drain2_state", 32'(a_state), 32'd3);
        tick(1);
        check("lit_off_state", 32'(a_state), 32'd0);
        check("lit_off_pena", 32'(a_pena), 32'd0);
        check("lit_off_run_a", 32'(a_run), 32'd23);
        check("lit_off_run_b", 32'(b_run), 32'd15);

        // Re-enable, then a one-cycle ena dip so ena_s returns in the first DRAIN cycle
        ena = 1'b1;
        tick(9);
        check("lit_rerun_run_a", 32'(a_run), 32'd2);
        ena = 1'b0;
        tick(1);
        ena = 1'b1;
        tick(2);
        check("lit_dip_drain", 32'(a_state), 32'd3);
        tick(1);
        check("lit_drain_not_short", 32'(a_state), 32'd3);
        check("lit_dip_run_hold", 32'(a_run), 32'd5);
        tick(1);
        check("lit_dip_reset", 32'(a_state), 32'd1);
        check("lit_dip_run_clr", 32'(a_run), 32'd0);

        // Asynchronous reset in the middle of RUN
        tick(6);
        check("lit_pre_async_state", 32'(a_state), 32'd2);
        rst_n = 1'b0;
        #1;
        check("lit_async_state_a", 32'(a_state), 32'd0);
        check("lit_async_state_b", 32'(b_state), 32'd0);
        check("lit_async_prst", 32'(a_prst), 32'd0);
        check("lit_async_ow_a", 32'(a_ow), 32'd0);
        check("lit_async_ow_b", 32'(b_ow), 32'd0);
        check("lit_async_run_a", 32'(a_run), 32'd0);
        check("lit_async_pena", 32'(b_pena), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        check("lit_post_rst_reset", 32'(a_state), 32'd1);

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
